ofmap_serializer: RTL and testbench

//  Downstream neighbour of the conv systolic-array datapath. Accepts one row of

---
 rtl/ofmap_serializer.sv | 114 +++++++++++
 tb/tb_ofmap_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_serializer.sv
// ofmap_serializer
//   Sits downstream of the conv systolic-array datapath. Takes one row of
//   ARRAY_WIDTH parallel ofmap words per handshake, holds up to two rows in a
//   ping-pong buffer, and streams them out one word per cycle, word 0 first.
//   A one-cycle tile_done pulse follows the release of the last row of each
//   NUM_ROWS-row tile so conv control can advance its banks.
//
// Ports
//   clk        in   1                        rising-edge clock
//   rst_n      in   1                        asynchronous active-low reset
//   row_dat    in   OFMAP_WIDTH*ARRAY_WIDTH  word i at [i*OFMAP_WIDTH +: OFMAP_WIDTH]
//   row_vld    in   1                        row_dat valid
//   row_rdy    out  1                        a row slot is free (registered)
//   ofmap_dat  out  OFMAP_WIDTH              current output word (0 when idle)
//   ofmap_vld  out  1                        ofmap_dat valid
//   ofmap_rdy  in   1                        consumer takes ofmap_dat
//   tile_done  out  1                        pulse after the last word of a tile

module ofmap_serializer #(
    parameter int OFMAP_WIDTH = 32,
    parameter int ARRAY_WIDTH = 8,
    parameter int NUM_ROWS    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] row_dat,
    input  logic                               row_vld,
    output logic                               row_rdy,
    output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
    output logic                               ofmap_vld,
    input  logic                               ofmap_rdy,
    output logic                               tile_done
);

    localparam int IDX_W = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] row_t;

    row_t             slot [2];
    row_t             cur_row;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic [IDX_W-1:0] widx;
    logic [ROW_W-1:0] row_cnt;
    logic             accept;
    logic             word_xfer;
    logic             row_release;

    assign accept      = row_vld && row_rdy;
    assign ofmap_vld   = (count != 2'd0);
    assign word_xfer   = ofmap_vld && ofmap_rdy;
    assign row_release = word_xfer && (widx == LAST_IDX);

    // Gating with ofmap_vld keeps the output at zero while idle or in reset,
    // so the row storage itself never needs a reset.
    assign cur_row   = slot[rd_ptr];
    assign ofmap_dat = ofmap_vld ? cur_row[widx] : '0;

    always_comb begin
        count_nxt = count;
        case ({accept, row_release})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // NOTE: row storage is a plain data path with no reset; stale contents are
    // never observable because count gates both ofmap_vld and ofmap_dat.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot[wr_ptr] <= row_dat;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            widx      <= '0;
            row_cnt   <= '0;
            row_rdy   <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            count <= count_nxt;
            // Registered from the next count: a release on a full buffer only
            // frees the slot from the following cycle, with no bypass path.
            row_rdy   <= (count_nxt != 2'd2);
            tile_done <= row_release && (row_cnt == LAST_ROW);

            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end

            if (word_xfer) begin
                widx <= (widx == LAST_IDX) ? '0 : widx + IDX_W'(1);
            end

            if (row_release) begin
                rd_ptr  <= ~rd_ptr;
                row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ofmap_serializer.sv
// Directed bench for ofmap_serializer. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge in between.

module tb_ofmap_serializer;

    localparam int W = 32;
    localparam int A = 8;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W*A-1:0]   row_dat = '0;
    logic             row_vld = 1'b0;
    logic             row_rdy;
    logic [W-1:0]     ofmap_dat;
    logic             ofmap_vld;
    logic             ofmap_rdy = 1'b0;
    logic             tile_done;

    int total = 0;
    int bad   = 0;

    ofmap_serializer #(
        .OFMAP_WIDTH(W),
        .ARRAY_WIDTH(A),
        .NUM_ROWS   (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_dat  (row_dat),
        .row_vld  (row_vld),
        .row_rdy  (row_rdy),
        .ofmap_dat(ofmap_dat),
        .ofmap_vld(ofmap_vld),
        .ofmap_rdy(ofmap_rdy),
        .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*A-1:0] mk_row(input logic [31:0] base);
        logic [W*A-1:0] r;
        for (int i = 0; i < A; i++) r[i*W +: W] = base + 32'(i);
        return r;
    endfunction

    function automatic logic [31:0] t5_base(input int r);
        return 32'hA000_0000 + (32'(r) << 8);
    endfunction

    initial begin
        int idx;
        int pushed;
        int w;
        int pulses;
        logic td_prev;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_row_rdy", row_rdy, 0);
        check("rst_ofmap_vld", ofmap_vld, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_ofmap_dat", ofmap_dat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_row_rdy", row_rdy, 1);
        check("post_rst_vld", ofmap_vld, 0);

        // ---------------- test 1: single row, rdy=1 ----------------
        ofmap_rdy = 1'b1;
        row_vld   = 1'b1;
        row_dat   = mk_row(32'h10);
        for (int i = 0; i < A; i++) begin
            @(negedge clk);
            row_vld = 1'b0;
            check("t1_vld", ofmap_vld, 1);
            check("t1_dat", ofmap_dat, 32'h10 + 32'(i));
        end
        @(negedge clk);
        check("t1_idle_vld", ofmap_vld, 0);
        check("t1_idle_dat", ofmap_dat, 0);
        check("t1_row_rdy", row_rdy, 1);

        // ---------------- test 2: fill with consumer stalled ----------------
        ofmap_rdy = 1'b0;
        row_vld   = 1'b1;
        row_dat   = mk_row(32'h20);
        @(negedge clk);
        check("t2_rdy_after_1", row_rdy, 1);
        check("t2_dat_row1", ofmap_dat, 32'h20);
        row_dat = mk_row(32'h30);
        @(negedge clk);
        check("t2_full_rdy", row_rdy, 0);
        check("t2_hold_dat", ofmap_dat, 32'h20);
        row_dat = mk_row(32'h40);
        @(negedge clk);
        check("t2_full_rdy2", row_rdy, 0);
        check("t2_hold_dat2", ofmap_dat, 32'h20);
        check("t2_vld", ofmap_vld, 1);

        // ---------------- test 3: drain from full ----------------
        ofmap_rdy = 1'b1;
        for (int i = 1; i < A; i++) begin
            @(negedge clk);
            check("t3_row1_dat", ofmap_dat, 32'h20 + 32'(i));
            check("t3_row1_rdy", row_rdy, 0);
        end
        @(negedge clk);
        check("t3_rdy_rise", row_rdy, 1);
        check("t3_row2_w0", ofmap_dat, 32'h30);
        @(negedge clk);
        row_vld = 1'b0;
        check("t3_full_again", row_rdy, 0);
        check("t3_row2_w1", ofmap_dat, 32'h31);
        for (int i = 2; i < A; i++) begin
            @(negedge clk);
            check("t3_row2_dat", ofmap_dat, 32'h30 + 32'(i));
        end
        for (int i = 0; i < A; i++) begin
            @(negedge clk);
            check("t3_row3_vld", ofmap_vld, 1);
            check("t3_row3_dat", ofmap_dat, 32'h40 + 32'(i));
        end
        @(negedge clk);
        check("t3_idle_vld", ofmap_vld, 0);

        // ---------------- test 4: toggling consumer ready ----------------
        ofmap_rdy = 1'b0;
        row_vld   = 1'b1;
        row_dat   = mk_row(32'h50);
        @(negedge clk);
        row_vld = 1'b0;
        idx = 0;
        for (int k = 0; k < 40 && idx < A; k++) begin
            check("t4_vld", ofmap_vld, 1);
            check("t4_dat", ofmap_dat, 32'h50 + 32'(idx));
            ofmap_rdy = (k % 2 == 0);
            if (ofmap_rdy) idx++;
            @(negedge clk);
        end
        check("t4_words", 32'(idx), A);
        check("t4_idle_vld", ofmap_vld, 0);

        // ---------------- test 6: reset mid-drain ----------------
        ofmap_rdy = 1'b0;
        row_vld   = 1'b1;
        row_dat   = mk_row(32'h60);
        @(negedge clk);
        row_dat = mk_row(32'h70);
        @(negedge clk);
        row_vld = 1'b0;
        check("t6_full", row_rdy, 0);
        check("t6_w0", ofmap_dat, 32'h60);
        ofmap_rdy = 1'b1;
        @(negedge clk);
        check("t6_w1", ofmap_dat, 32'h61);
        @(negedge clk);
        check("t6_w2", ofmap_dat, 32'h62);
        @(negedge clk);
        check("t6_w3", ofmap_dat, 32'h63);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", ofmap_vld, 0);
        check("t6_rst_rdy", row_rdy, 0);
        check("t6_rst_dat", ofmap_dat, 0);
        check("t6_rst_td", tile_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rel_rdy", row_rdy, 1);
        check("t6_rel_vld", ofmap_vld, 0);
        row_vld = 1'b1;
        row_dat = mk_row(32'h80);
        for (int i = 0; i < A; i++) begin
            @(negedge clk);
            row_vld = 1'b0;
            check("t6_new_dat", ofmap_dat, 32'h80 + 32'(i));
        end
        @(negedge clk);
        check("t6_discarded", ofmap_vld, 0);

        // ---------------- test 5: two full tiles back-to-back ----------------
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ofmap_rdy = 1'b1;
        pushed  = 0;
        w       = 0;
        pulses  = 0;
        td_prev = 1'b0;
        for (int cyc = 0; cyc < 400 && w < 2 * N * A; cyc++) begin
            @(negedge clk);
            check("t5_tile_done", tile_done, td_prev);
            if (tile_done) pulses++;
            if (w > 0) check("t5_no_bubble", ofmap_vld, 1);
            td_prev = 1'b0;
            if (ofmap_vld) begin
                check("t5_dat", ofmap_dat, t5_base(w / A) + 32'(w % A));
                td_prev = (w % (N * A) == N * A - 1);
                w++;
            end
            row_vld = (pushed < 2 * N);
            row_dat = mk_row(t5_base(pushed));
            if (row_vld && row_rdy) pushed++;
        end
        check("t5_word_count", 32'(w), 2 * N * A);
        @(negedge clk);
        row_vld = 1'b0;
        check("t5_last_tile_done", tile_done, td_prev);
        if (tile_done) pulses++;
        @(negedge clk);
        check("t5_td_single", tile_done, 0);
        check("t5_pulses", 32'(pulses), 2);
        check("t5_idle", ofmap_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
